// File: rtl/instr_fetch_decode_if.sv
// Fetch/decode bus: redirect and stall controls, instruction-memory handshake,
// and decoded fields handed to the control stage.
interface instr_fetch_decode_if;
  logic        stall;
  logic        branch_taken;
  logic [63:0] branch_target;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_valid;
  logic        instr_valid;
  logic [63:0] pc_out;
  logic [6:0]  Opcode;
  logic [3:0]  Funct;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [4:0]  rd;
  logic [63:0] imm;

  modport master (
    input  stall, branch_taken, branch_target, imem_rdata, imem_valid,
    output imem_req, imem_addr, instr_valid, pc_out, Opcode, Funct, rs1, rs2, rd, imm
  );

  modport slave (
    output stall, branch_taken, branch_target, imem_rdata, imem_valid,
    input  imem_req, imem_addr, instr_valid, pc_out, Opcode, Funct, rs1, rs2, rd, imm
  );
endinterface

// File: rtl/instr_fetch_decode.sv
// Three-state fetch/issue unit: requests one instruction word at PC, latches it
// into IR and presents combinational decode fields until downstream accepts.
module instr_fetch_decode (
  input  logic                  clk,
  input  logic                  reset_n,
  instr_fetch_decode_if.master  bus
);
  typedef enum logic [1:0] {IDLE, FETCH, ISSUE} state_t;

  localparam logic [31:0] NOP = 32'h0000_0013;

  state_t      r_state;
  logic [63:0] r_pc;
  logic [63:0] r_pc_out;
  logic [31:0] r_ir;
  logic        r_imem_req;
  logic        r_instr_valid;

  logic [63:0] w_redirect;
  logic [63:0] w_imm;

  assign w_redirect = {bus.branch_target[63:2], 2'b00};

  // A redirect always wins over stall and over a same-cycle memory response.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state       <= IDLE;
      r_pc          <= 64'd0;
      r_ir          <= NOP;
      r_pc_out      <= 64'd0;
      r_imem_req    <= 1'b0;
      r_instr_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_state    <= FETCH;
          r_imem_req <= 1'b1;
        end
        FETCH: begin
          if (bus.branch_taken) begin
            r_pc          <= w_redirect;
            r_imem_req    <= 1'b1;
            r_instr_valid <= 1'b0;
          end else if (bus.imem_valid) begin
            r_ir          <= bus.imem_rdata;
            r_pc_out      <= r_pc;
            r_pc          <= r_pc + 64'd4;
            r_state       <= ISSUE;
            r_imem_req    <= 1'b0;
            r_instr_valid <= 1'b1;
          end
        end
        ISSUE: begin
          if (bus.branch_taken) begin
            r_pc          <= w_redirect;
            r_state       <= FETCH;
            r_imem_req    <= 1'b1;
            r_instr_valid <= 1'b0;
          end else if (!bus.stall) begin
            r_state       <= FETCH;
            r_imem_req    <= 1'b1;
            r_instr_valid <= 1'b0;
          end
        end
        default: begin
          r_state       <= IDLE;
          r_imem_req    <= 1'b0;
          r_instr_valid <= 1'b0;
        end
      endcase
    end
  end

  // Only loads, ALU-immediates, stores and branches carry an immediate.
  always_comb begin
    w_imm = 64'd0;
    case (r_ir[6:0])
      7'b0000011,
      7'b0010011: w_imm = {{52{r_ir[31]}}, r_ir[31:20]};
      7'b0100011: w_imm = {{52{r_ir[31]}}, r_ir[31:25], r_ir[11:7]};
      7'b1100011: w_imm = {{51{r_ir[31]}}, r_ir[31], r_ir[7], r_ir[30:25], r_ir[11:8], 1'b0};
      default:    w_imm = 64'd0;
    endcase
  end

  assign bus.imem_req    = r_imem_req;
  assign bus.imem_addr   = r_pc;
  assign bus.instr_valid = r_instr_valid;
  assign bus.pc_out      = r_pc_out;
  assign bus.Opcode      = r_ir[6:0];
  assign bus.Funct       = {r_ir[30], r_ir[14:12]};
  assign bus.rs1         = r_ir[19:15];
  assign bus.rs2         = r_ir[24:20];
  assign bus.rd          = r_ir[11:7];
  assign bus.imm         = w_imm;
endmodule

// File: tb/tb_instr_fetch_decode.sv
// Bench for instr_fetch_decode: directed vector table, hand-written corner
// sequences, then random traffic checked against a transaction-level model.
module tb_instr_fetch_decode;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  instr_fetch_decode_if bus ();
  instr_fetch_decode dut (.clk(clk), .reset_n(reset_n), .bus(bus));

  int n_pass = 0;
  int n_total = 0;
  logic [63:0] exp_pc;

  typedef struct {
    logic [31:0] ir;
    logic [6:0]  op;
    logic [3:0]  fn;
    logic [4:0]  rs1, rs2, rd;
    logic [63:0] imm;
  } vec_t;
  vec_t tbl[6];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", nm, act, exp);
  endtask

  // Reference decode, from the field definitions using integer arithmetic.
  function automatic logic [63:0] ref_imm(input logic [31:0] ir);
    int    s  = ir;
    longint ls = longint'(s);
    case (ir % 128)
      3, 19:   return ls >>> 20;
      35:      return (ls >>> 25) * 32 + longint'((ir >> 7) % 32);
      99:      return (ls >>> 31) * 4096 + longint'((ir >> 7) % 2) * 2048
                      + longint'((ir >> 25) % 64) * 32 + longint'((ir >> 8) % 16) * 2;
      default: return 64'd0;
    endcase
  endfunction

  task automatic chk_issue(input logic [31:0] ir, input logic [63:0] pc);
    chk("iss_valid", 64'(bus.instr_valid), 64'd1);
    chk("iss_pc_out", bus.pc_out, pc);
    chk("iss_opcode", 64'(bus.Opcode), 64'(ir % 128));
    chk("iss_funct", 64'(bus.Funct), 64'(((ir >> 30) % 2) * 8 + (ir >> 12) % 8));
    chk("iss_rs1", 64'(bus.rs1), 64'((ir >> 15) % 32));
    chk("iss_rs2", 64'(bus.rs2), 64'((ir >> 20) % 32));
    chk("iss_rd", 64'(bus.rd), 64'((ir >> 7) % 32));
    chk("iss_imm", bus.imm, ref_imm(ir));
  endtask

  // Called in FETCH: insert wait cycles, then deliver one word (ISSUE after).
  task automatic fetch(input logic [31:0] ir, input int waits);
    for (int w = 0; w < waits; w++) begin
      chk("wait_req", 64'(bus.imem_req), 64'd1);
      chk("wait_addr", bus.imem_addr, exp_pc);
      tick();
    end
    chk("fetch_req", 64'(bus.imem_req), 64'd1);
    chk("fetch_addr", bus.imem_addr, exp_pc);
    bus.imem_valid = 1'b1;
    bus.imem_rdata = ir;
    tick();
    bus.imem_valid = 1'b0;
    bus.imem_rdata = $urandom;
    exp_pc = exp_pc + 64'd4;
  endtask

  task automatic release_issue();
    bus.stall = 1'b0;
    tick();
    chk("rel_valid", 64'(bus.instr_valid), 64'd0);
    chk("rel_req", 64'(bus.imem_req), 64'd1);
    chk("rel_addr", bus.imem_addr, exp_pc);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    tick();
    tick();
    chk("rst_req", 64'(bus.imem_req), 64'd0);
    chk("rst_valid", 64'(bus.instr_valid), 64'd0);
    chk("rst_addr", bus.imem_addr, 64'd0);
    chk("rst_pc_out", bus.pc_out, 64'd0);
    chk("rst_opcode", 64'(bus.Opcode), 64'h13);
    reset_n = 1'b1;
    tick();
    exp_pc = 64'd0;
    chk("post_rst_req", 64'(bus.imem_req), 64'd1);
    chk("post_rst_addr", bus.imem_addr, 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] ir, prev_ir;
    logic [63:0] tgt, hold_pc, hold_imm;
    logic [6:0]  hold_op;

    tbl[0] = '{32'h402081B3, 7'h33, 4'b1000, 5'd1, 5'd2, 5'd3, 64'd0};
    tbl[1] = '{32'h00813283, 7'h03, 4'b0011, 5'd2, 5'd8, 5'd5, 64'd8};
    tbl[2] = '{32'hFE208CE3, 7'h63, 4'b1000, 5'd1, 5'd2, 5'd25, 64'hFFFF_FFFF_FFFF_FFF8};
    tbl[3] = '{32'hFE112E23, 7'h23, 4'b1010, 5'd2, 5'd1, 5'd28, 64'hFFFF_FFFF_FFFF_FFFC};
    tbl[4] = '{32'hFFFFF0B7, 7'h37, 4'b1111, 5'd31, 5'd31, 5'd1, 64'd0};
    tbl[5] = '{32'hFFF00093, 7'h13, 4'b1000, 5'd0, 5'd31, 5'd1, 64'hFFFF_FFFF_FFFF_FFFF};

    bus.stall = 1'b0;
    bus.branch_taken = 1'b0;
    bus.branch_target = 64'd0;
    bus.imem_rdata = 32'd0;
    bus.imem_valid = 1'b0;
    exp_pc = 64'd0;

    // Basic add at address 0, zero-wait memory.
    do_reset();
    fetch(32'h002081B3, 0);
    chk("add_valid", 64'(bus.instr_valid), 64'd1);
    chk("add_pc_out", bus.pc_out, 64'd0);
    chk("add_opcode", 64'(bus.Opcode), 64'h33);
    chk("add_funct", 64'(bus.Funct), 64'd0);
    chk("add_rs1", 64'(bus.rs1), 64'd1);
    chk("add_rs2", 64'(bus.rs2), 64'd2);
    chk("add_rd", 64'(bus.rd), 64'd3);
    chk("add_imm", bus.imm, 64'd0);
    release_issue();
    chk("add_next_addr", bus.imem_addr, 64'd4);

    // Directed vector table from a fresh reset.
    do_reset();
    for (int i = 0; i < 6; i++) begin
      hold_pc = exp_pc;
      fetch(tbl[i].ir, i % 2);
      chk("tbl_valid", 64'(bus.instr_valid), 64'd1);
      chk("tbl_pc_out", bus.pc_out, hold_pc);
      chk("tbl_opcode", 64'(bus.Opcode), 64'(tbl[i].op));
      chk("tbl_funct", 64'(bus.Funct), 64'(tbl[i].fn));
      chk("tbl_rs1", 64'(bus.rs1), 64'(tbl[i].rs1));
      chk("tbl_rs2", 64'(bus.rs2), 64'(tbl[i].rs2));
      chk("tbl_rd", 64'(bus.rd), 64'(tbl[i].rd));
      chk("tbl_imm", bus.imm, tbl[i].imm);
      release_issue();
    end

    // Stall holds everything for three cycles.
    fetch(32'h00813283, 0);
    hold_pc = bus.pc_out;
    bus.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_valid", 64'(bus.instr_valid), 64'd1);
      chk("stall_req", 64'(bus.imem_req), 64'd0);
      chk("stall_pc_out", bus.pc_out, hold_pc);
      chk("stall_opcode", 64'(bus.Opcode), 64'h03);
      chk("stall_imm", bus.imm, 64'd8);
    end
    release_issue();

    // Redirect in FETCH beats a same-cycle response; data is dropped.
    prev_ir = 32'h00813283;
    bus.branch_taken = 1'b1;
    bus.branch_target = 64'h103;
    bus.imem_valid = 1'b1;
    bus.imem_rdata = 32'h002081B3;
    bus.stall = 1'b1;
    tick();
    bus.branch_taken = 1'b0;
    bus.imem_valid = 1'b0;
    bus.stall = 1'b0;
    exp_pc = 64'h100;
    chk("brf_valid", 64'(bus.instr_valid), 64'd0);
    chk("brf_addr", bus.imem_addr, 64'h100);
    chk("brf_req", 64'(bus.imem_req), 64'd1);
    chk("brf_ir_kept", 64'(bus.Opcode), 64'(prev_ir % 128));

    // Redirect in ISSUE while stalled.
    fetch(32'hFE208CE3, 1);
    hold_pc = bus.pc_out;
    bus.stall = 1'b1;
    tick();
    chk("bri_hold", 64'(bus.instr_valid), 64'd1);
    bus.branch_taken = 1'b1;
    bus.branch_target = 64'h203;
    tick();
    bus.branch_taken = 1'b0;
    bus.stall = 1'b0;
    exp_pc = 64'h200;
    chk("bri_valid", 64'(bus.instr_valid), 64'd0);
    chk("bri_addr", bus.imem_addr, 64'h200);
    chk("bri_req", 64'(bus.imem_req), 64'd1);
    chk("bri_pc_out", bus.pc_out, hold_pc);

    // PC wraps modulo 2^64.
    bus.branch_taken = 1'b1;
    bus.branch_target = 64'hFFFF_FFFF_FFFF_FFFF;
    tick();
    bus.branch_taken = 1'b0;
    exp_pc = 64'hFFFF_FFFF_FFFF_FFFC;
    chk("wrap_addr", bus.imem_addr, exp_pc);
    fetch(32'h00000013, 0);
    chk("wrap_pc_out", bus.pc_out, 64'hFFFF_FFFF_FFFF_FFFC);
    release_issue();
    chk("wrap_zero", bus.imem_addr, 64'd0);

    // Reset in mid-FETCH with a wait state; late response is ignored.
    fetch(32'h402081B3, 0);
    release_issue();
    tick();
    reset_n = 1'b0;
    tick();
    chk("rmid_req", 64'(bus.imem_req), 64'd0);
    chk("rmid_addr", bus.imem_addr, 64'd0);
    chk("rmid_valid", 64'(bus.instr_valid), 64'd0);
    bus.imem_valid = 1'b1;
    bus.imem_rdata = 32'h00813283;
    tick();
    chk("rlate_opcode", 64'(bus.Opcode), 64'h13);
    chk("rlate_valid", 64'(bus.instr_valid), 64'd0);
    reset_n = 1'b1;
    tick();
    bus.imem_valid = 1'b0;
    exp_pc = 64'd0;
    chk("rrel_req", 64'(bus.imem_req), 64'd1);
    chk("rrel_addr", bus.imem_addr, 64'd0);
    chk("rrel_valid", 64'(bus.instr_valid), 64'd0);
    chk("rrel_opcode", 64'(bus.Opcode), 64'h13);

    // Random traffic against the transaction-level model.
    for (int it = 0; it < 300; it++) begin
      if ($urandom_range(7) == 0) begin
        for (int w = 0; w < int'($urandom_range(2)); w++) begin
          chk("rnd_wait_addr", bus.imem_addr, exp_pc);
          tick();
        end
        tgt = {$urandom, $urandom};
        bus.branch_taken = 1'b1;
        bus.branch_target = tgt;
        bus.imem_valid = 1'($urandom);
        bus.imem_rdata = $urandom;
        tick();
        bus.branch_taken = 1'b0;
        bus.imem_valid = 1'b0;
        exp_pc = tgt & ~64'd3;
        chk("rnd_brf_valid", 64'(bus.instr_valid), 64'd0);
        chk("rnd_brf_addr", bus.imem_addr, exp_pc);
        continue;
      end
      ir = $urandom;
      case ($urandom_range(5))
        0: ir[6:0] = 7'h03;
        1: ir[6:0] = 7'h13;
        2: ir[6:0] = 7'h23;
        3: ir[6:0] = 7'h63;
        4: ir[6:0] = 7'h33;
        default: ;
      endcase
      hold_pc = exp_pc;
      fetch(ir, int'($urandom_range(2)));
      chk_issue(ir, hold_pc);
      hold_op = bus.Opcode;
      hold_imm = bus.imm;
      bus.stall = 1'b1;
      for (int s = 0; s < int'($urandom_range(2)); s++) begin
        tick();
        chk("rnd_stall_valid", 64'(bus.instr_valid), 64'd1);
        chk("rnd_stall_req", 64'(bus.imem_req), 64'd0);
        chk("rnd_stall_pc", bus.pc_out, hold_pc);
        chk("rnd_stall_op", 64'(bus.Opcode), 64'(hold_op));
        chk("rnd_stall_imm", bus.imm, hold_imm);
      end
      if ($urandom_range(4) == 0) begin
        tgt = {$urandom, $urandom};
        bus.branch_taken = 1'b1;
        bus.branch_target = tgt;
        tick();
        bus.branch_taken = 1'b0;
        bus.stall = 1'b0;
        exp_pc = tgt & ~64'd3;
        chk("rnd_bri_valid", 64'(bus.instr_valid), 64'd0);
        chk("rnd_bri_addr", bus.imem_addr, exp_pc);
      end else begin
        release_issue();
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
